tl_ul_mem_slave: RTL and testbench

Synthesizable TileLink-UL single-beat memory slave serving one 32-bit TL port (A in, D out). It sits directly downstream of the vector core's `tlPort_*` A channel, in place of the behavioural reference-model memory, so the core can run with a purely RTL memory. Requests pass through a fixed-latency, in-order response queue with per-entry countdowns.

---
 rtl/tl_ul_mem_slave.sv | 173 +++++++++++++++++
 tb/tb_tl_ul_mem_slave.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_mem_slave.sv
// TileLink-UL single-beat 32-bit memory slave with a fixed-latency, in-order response queue.
// Optional build macro: TL_MEM_MISALIGN_DENY_EN (deny misaligned size-1/size-2 accesses).
module tl_ul_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter int          RESP_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tl_a_valid,
  output logic        tl_a_ready,
  input  logic [2:0]  tl_a_bits_opcode,
  input  logic [2:0]  tl_a_bits_param,
  input  logic [1:0]  tl_a_bits_size,
  input  logic [9:0]  tl_a_bits_source,
  input  logic [31:0] tl_a_bits_address,
  input  logic [3:0]  tl_a_bits_mask,
  input  logic [31:0] tl_a_bits_data,
  input  logic        tl_a_bits_corrupt,
  output logic        tl_d_valid,
  input  logic        tl_d_ready,
  output logic [2:0]  tl_d_bits_opcode,
  output logic [2:0]  tl_d_bits_param,
  output logic [1:0]  tl_d_bits_size,
  output logic [9:0]  tl_d_bits_source,
  output logic [9:0]  tl_d_bits_sink,
  output logic        tl_d_bits_denied,
  output logic [31:0] tl_d_bits_data,
  output logic        tl_d_bits_corrupt
);

  localparam int                AW       = $clog2(DEPTH_WORDS);
  localparam int                PW       = $clog2(RESP_DEPTH);
  localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
  localparam logic [PW:0]       OCC_ONE  = (PW+1)'(1);
  localparam logic [PW:0]       OCC_FULL = (PW+1)'(RESP_DEPTH);

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [2:0]    r_q_op   [RESP_DEPTH];
  logic [1:0]    r_q_size [RESP_DEPTH];
  logic [9:0]    r_q_src  [RESP_DEPTH];
  logic          r_q_den  [RESP_DEPTH];
  logic [31:0]   r_q_data [RESP_DEPTH];
  logic [3:0]    r_q_cnt  [RESP_DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          r_ready_en;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_is_put;
  logic          w_is_get;
  logic          w_op_ok;
  logic          w_oor;
  logic          w_misalign;
  logic          w_denied;
  logic          w_accept;
  logic          w_pop;
  logic          w_d_valid;
  logic [2:0]    w_push_op;
  logic [31:0]   w_push_data;
  logic          w_unused;

  assign w_off    = tl_a_bits_address - BASE_ADDR;
  assign w_idx    = w_off[AW+1:2];
  assign w_unused = ^{tl_a_bits_param, w_off[1:0]};

  // Request decode: classify opcode and evaluate every denial condition.
  always_comb begin
    w_is_put   = (tl_a_bits_opcode == 3'd0) || (tl_a_bits_opcode == 3'd1);
    w_is_get   = (tl_a_bits_opcode == 3'd4);
    w_op_ok    = w_is_put || w_is_get;
    w_oor      = (tl_a_bits_address < BASE_ADDR) || (w_off[31:2] >= 30'(DEPTH_WORDS));
`ifdef TL_MEM_MISALIGN_DENY_EN
    w_misalign = ((tl_a_bits_size == 2'd1) && tl_a_bits_address[0]) ||
                 ((tl_a_bits_size == 2'd2) && (tl_a_bits_address[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_denied   = !w_op_ok || (tl_a_bits_size == 2'd3) || w_oor ||
                 (w_is_put && tl_a_bits_corrupt) || w_misalign;
    w_push_op  = w_is_get ? 3'd1 : 3'd0;
    if (w_is_get && !w_denied) begin
      w_push_data = r_mem[w_idx];
    end else begin
      w_push_data = 32'h0000_0000;
    end
  end

  assign tl_a_ready = r_ready_en && (r_count < OCC_FULL);
  assign w_accept   = tl_a_valid && tl_a_ready;
  assign w_d_valid  = (r_count != {(PW+1){1'b0}}) && (r_q_cnt[r_rptr] == 4'd0);
  assign w_pop      = w_d_valid && tl_d_ready;

  // Byte-lane writes; memory deliberately has no reset so contents survive it.
  always_ff @(posedge clock) begin
    if (w_accept && w_is_put && !w_denied) begin
      for (int b = 0; b < 4; b++) begin
        if (tl_a_bits_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= tl_a_bits_data[8*b +: 8];
        end
      end
    end
  end

  // Queue control: pointers, occupancy and per-entry saturating countdowns.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr     <= {PW{1'b0}};
      r_rptr     <= {PW{1'b0}};
      r_count    <= {(PW+1){1'b0}};
      r_ready_en <= 1'b0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        r_q_cnt[i] <= 4'd0;
      end
    end else begin
      r_ready_en <= 1'b1;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        r_q_cnt[i] <= (r_q_cnt[i] != 4'd0) ? (r_q_cnt[i] - 4'd1) : 4'd0;
      end
      if (w_accept) begin
        r_q_cnt[r_wptr] <= CNT_INIT;
        r_wptr          <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload storage, written only on accept.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_q_op[r_wptr]   <= w_push_op;
      r_q_size[r_wptr] <= tl_a_bits_size;
      r_q_src[r_wptr]  <= tl_a_bits_source;
      r_q_den[r_wptr]  <= w_denied;
      r_q_data[r_wptr] <= w_push_data;
    end
  end

  // D channel: head entry presented only while valid, zero otherwise.
  always_comb begin
    tl_d_valid        = w_d_valid;
    tl_d_bits_param   = 3'd0;
    tl_d_bits_sink    = 10'd0;
    tl_d_bits_corrupt = 1'b0;
    if (w_d_valid) begin
      tl_d_bits_opcode = r_q_op[r_rptr];
      tl_d_bits_size   = r_q_size[r_rptr];
      tl_d_bits_source = r_q_src[r_rptr];
      tl_d_bits_denied = r_q_den[r_rptr];
      tl_d_bits_data   = r_q_data[r_rptr];
    end else begin
      tl_d_bits_opcode = 3'd0;
      tl_d_bits_size   = 2'd0;
      tl_d_bits_source = 10'd0;
      tl_d_bits_denied = 1'b0;
      tl_d_bits_data   = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_tl_ul_mem_slave.sv
// Directed table-driven bench for tl_ul_mem_slave (default parameters, LATENCY=2, RESP_DEPTH=4).
module tb_tl_ul_mem_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tl_a_valid = 1'b0;
  logic        tl_a_ready;
  logic [2:0]  tl_a_bits_opcode = 3'd0;
  logic [2:0]  tl_a_bits_param = 3'd0;
  logic [1:0]  tl_a_bits_size = 2'd0;
  logic [9:0]  tl_a_bits_source = 10'd0;
  logic [31:0] tl_a_bits_address = 32'h0;
  logic [3:0]  tl_a_bits_mask = 4'h0;
  logic [31:0] tl_a_bits_data = 32'h0;
  logic        tl_a_bits_corrupt = 1'b0;
  logic        tl_d_valid;
  logic        tl_d_ready = 1'b0;
  logic [2:0]  tl_d_bits_opcode;
  logic [2:0]  tl_d_bits_param;
  logic [1:0]  tl_d_bits_size;
  logic [9:0]  tl_d_bits_source;
  logic [9:0]  tl_d_bits_sink;
  logic        tl_d_bits_denied;
  logic [31:0] tl_d_bits_data;
  logic        tl_d_bits_corrupt;

  int n_vec = 0;
  int n_err = 0;

  tl_ul_mem_slave dut (
    .clock(clock), .reset(reset),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready),
    .tl_a_bits_opcode(tl_a_bits_opcode), .tl_a_bits_param(tl_a_bits_param),
    .tl_a_bits_size(tl_a_bits_size), .tl_a_bits_source(tl_a_bits_source),
    .tl_a_bits_address(tl_a_bits_address), .tl_a_bits_mask(tl_a_bits_mask),
    .tl_a_bits_data(tl_a_bits_data), .tl_a_bits_corrupt(tl_a_bits_corrupt),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready),
    .tl_d_bits_opcode(tl_d_bits_opcode), .tl_d_bits_param(tl_d_bits_param),
    .tl_d_bits_size(tl_d_bits_size), .tl_d_bits_source(tl_d_bits_source),
    .tl_d_bits_sink(tl_d_bits_sink), .tl_d_bits_denied(tl_d_bits_denied),
    .tl_d_bits_data(tl_d_bits_data), .tl_d_bits_corrupt(tl_d_bits_corrupt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [9:0]  src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
    logic [2:0]  e_op;
    logic        e_den;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] size, input logic [9:0] src,
                              input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                              input logic corrupt, input logic [2:0] e_op, input logic e_den,
                              input logic [31:0] e_data);
    vec_t v;
    v.op = op; v.size = size; v.src = src; v.addr = addr; v.mask = mask; v.data = data;
    v.corrupt = corrupt; v.e_op = e_op; v.e_den = e_den; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [1:0] size, input logic [9:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                         input logic corrupt);
    tl_a_valid = 1'b1; tl_a_bits_opcode = op; tl_a_bits_size = size; tl_a_bits_source = src;
    tl_a_bits_address = addr; tl_a_bits_mask = mask; tl_a_bits_data = data;
    tl_a_bits_corrupt = corrupt; tl_a_bits_param = 3'd5;
  endtask

  // One clock step; drops a_valid once the pending request has been accepted.
  task automatic tick();
    logic acc;
    acc = tl_a_valid && tl_a_ready;
    @(posedge clock);
    #1;
    if (acc) tl_a_valid = 1'b0;
  endtask

  task automatic wait_d(input string nm, input int budget);
    int k;
    k = 0;
    while (!tl_d_valid && k < budget) begin
      tick();
      k++;
    end
    if (!tl_d_valid) check({nm, "_timeout"}, 32'(tl_d_valid), 32'd1);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", i);
    tl_d_ready = 1'b1;
    drive_a(v.op, v.size, v.src, v.addr, v.mask, v.data, v.corrupt);
    check({nm, "_a_ready"}, 32'(tl_a_ready), 32'd1);
    tick();
    check({nm, "_early_valid"}, 32'(tl_d_valid), 32'd0);
    tick();
    check({nm, "_d_valid"}, 32'(tl_d_valid), 32'd1);
    check({nm, "_opcode"}, 32'(tl_d_bits_opcode), 32'(v.e_op));
    check({nm, "_denied"}, 32'(tl_d_bits_denied), 32'(v.e_den));
    check({nm, "_data"}, tl_d_bits_data, v.e_data);
    check({nm, "_source"}, 32'(tl_d_bits_source), 32'(v.src));
    check({nm, "_size"}, 32'(tl_d_bits_size), 32'(v.size));
    tick();
    check({nm, "_popped"}, 32'(tl_d_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] e_mis_data;
    logic        e_mis_den;
`ifdef TL_MEM_MISALIGN_DENY_EN
    e_mis_den = 1'b1; e_mis_data = 32'h0000_0000;
`else
    e_mis_den = 1'b0; e_mis_data = 32'h1234_BB78;
`endif
    //            op    sz    src     addr           mask   data          cor   eop   eden  edata
    vt[0]  = mk(3'd0, 2'd2, 10'd5,  32'h0000_0010, 4'hF, 32'h1234_5678, 1'b0, 3'd0, 1'b0, 32'h0);
    vt[1]  = mk(3'd4, 2'd2, 10'd6,  32'h0000_0010, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0, 32'h1234_5678);
    vt[2]  = mk(3'd1, 2'd2, 10'd7,  32'h0000_0010, 4'h2, 32'hAAAA_BBBB, 1'b0, 3'd0, 1'b0, 32'h0);
    vt[3]  = mk(3'd4, 2'd2, 10'd8,  32'h0000_0010, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0, 32'h1234_BB78);
    vt[4]  = mk(3'd6, 2'd2, 10'd9,  32'h0000_0010, 4'hF, 32'h5555_5555, 1'b0, 3'd0, 1'b1, 32'h0);
    vt[5]  = mk(3'd0, 2'd3, 10'd10, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b1, 32'h0);
    vt[6]  = mk(3'd4, 2'd2, 10'd11, 32'h0000_1000, 4'hF, 32'h0,         1'b0, 3'd1, 1'b1, 32'h0);
    vt[7]  = mk(3'd0, 2'd2, 10'd12, 32'h0000_1000, 4'hF, 32'h0BAD_0BAD, 1'b0, 3'd0, 1'b1, 32'h0);
    vt[8]  = mk(3'd0, 2'd2, 10'd13, 32'h0000_0010, 4'hF, 32'h0000_0000, 1'b1, 3'd0, 1'b1, 32'h0);
    vt[9]  = mk(3'd4, 2'd2, 10'd14, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0, 32'h1234_BB78);
    vt[10] = mk(3'd4, 2'd2, 10'd15, 32'h0000_0012, 4'hF, 32'h0,         1'b0, 3'd1, e_mis_den, e_mis_data);
    vt[11] = mk(3'd0, 2'd2, 10'd16, 32'h0000_0FFC, 4'hF, 32'hCAFE_F00D, 1'b0, 3'd0, 1'b0, 32'h0);
    vt[12] = mk(3'd4, 2'd2, 10'd1023, 32'h0000_0FFC, 4'hF, 32'h0,       1'b0, 3'd1, 1'b0, 32'hCAFE_F00D);
    vt[13] = mk(3'd0, 2'd2, 10'd17, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF, 1'b0, 3'd0, 1'b0, 32'h0);
    vt[14] = mk(3'd1, 2'd2, 10'd18, 32'h0000_0020, 4'h9, 32'h1122_3344, 1'b0, 3'd0, 1'b0, 32'h0);
    vt[15] = mk(3'd4, 2'd2, 10'd19, 32'h0000_0020, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0, 32'h11AD_BE44);

    #1;
    check("rst_a_ready", 32'(tl_a_ready), 32'd0);
    check("rst_d_valid", 32'(tl_d_valid), 32'd0);
    check("rst_d_data", tl_d_bits_data, 32'h0);
    check("rst_d_source", 32'(tl_d_bits_source), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    tick();
    check("post_rst_a_ready", 32'(tl_a_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i, vt[i]);

    // Backpressure: five Gets with D stalled, then drain in order.
    tl_d_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_a(3'd4, 2'd2, 10'(20 + k), 32'h0000_0010, 4'hF, 32'h0, 1'b0);
      check($sformatf("bp_a_ready%0d", k), 32'(tl_a_ready), (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) tick();
    end
    tick();
    check("bp_full_ready", 32'(tl_a_ready), 32'd0);
    check("bp_hold_valid", 32'(tl_d_valid), 32'd1);
    check("bp_hold_source", 32'(tl_d_bits_source), 32'd20);
    tl_d_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      wait_d($sformatf("bp_resp%0d", r), 20);
      check($sformatf("bp_src%0d", r), 32'(tl_d_bits_source), 32'(20 + r));
      check($sformatf("bp_data%0d", r), tl_d_bits_data, 32'h1234_BB78);
      tick();
    end
    check("bp_drained", 32'(tl_d_valid), 32'd0);

    // Reset with three responses queued.
    tl_d_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_a(3'd4, 2'd2, 10'(30 + k), 32'h0000_0010, 4'hF, 32'h0, 1'b0);
      tick();
    end
    tick();
    check("pre_rst_valid", 32'(tl_d_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(tl_d_valid), 32'd0);
    check("mid_rst_ready", 32'(tl_a_ready), 32'd0);
    check("mid_rst_source", 32'(tl_d_bits_source), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    check("rel_rst_ready", 32'(tl_a_ready), 32'd1);
    tl_d_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("no_stale%0d", k), 32'(tl_d_valid), 32'd0);
      tick();
    end
    run_vec(99, mk(3'd4, 2'd2, 10'd40, 32'h0000_0010, 4'hF, 32'h0, 1'b0, 3'd1, 1'b0, 32'h1234_BB78));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
